// File: rtl/smart_lighting_pkg.sv
// Shared types and sizing helpers for the smart lighting controller.
// Optional input synchronizer is selected with SLS_INPUT_SYNC_EN (see top).
package smart_lighting_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ON      = 3'd1,
    S_DIM     = 3'd2,
    S_MAN_ON  = 3'd3,
    S_MAN_OFF = 3'd4
  } sls_state_e;

  // Width able to hold the largest of the hold, dim and PWM counts.
  function automatic int sls_cnt_w(input int hold, input int dim, input int period);
    int m;
    m = hold;
    if (dim > m) m = dim;
    if (period > m) m = period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/smart_lighting_ctrl_if.sv
// Sensor/switch inputs and lamp drive of the lighting controller.
// Optional input synchronizer is selected with SLS_INPUT_SYNC_EN (see top).
interface smart_lighting_ctrl_if;
  logic motion;
  logic light_level;
  logic manual_on;
  logic manual_off;
  logic light;

  modport master (
    output motion, light_level, manual_on, manual_off,
    input  light
  );

  modport slave (
    input  motion, light_level, manual_on, manual_off,
    output light
  );
endinterface

// File: rtl/sls_pwm_dimmer.sv
// Dim-mode PWM counter; o_on_nxt is the lamp level for the counter value after this edge.
// Optional input synchronizer is selected with SLS_INPUT_SYNC_EN (see top).
module sls_pwm_dimmer #(
  parameter int PWM_PERIOD = 4,
  parameter int DIM_DUTY   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_on_nxt
);
  localparam int PW = $clog2(PWM_PERIOD);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (i_en)
      w_cnt_nxt = (r_cnt == PW'(PWM_PERIOD - 1)) ? '0 : r_cnt + PW'(1);
  end

  assign o_on_nxt = (w_cnt_nxt < PW'(DIM_DUTY));

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end
endmodule

// File: rtl/smart_lighting_ctrl.sv
// Room-lighting controller: motion-at-night lamp with full-hold, PWM dim, then off; manual overrides.
// Define SLS_INPUT_SYNC_EN to add 2-flop input synchronizers (3-cycle input-to-light latency).
module smart_lighting_ctrl
  import smart_lighting_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DIM_CYCLES  = 8,
  parameter int PWM_PERIOD  = 4,
  parameter int DIM_DUTY    = 1
) (
  input  logic clk,
  input  logic reset,
  smart_lighting_ctrl_if.slave bus
);
  localparam int CW = sls_cnt_w(HOLD_CYCLES, DIM_CYCLES, PWM_PERIOD);

  localparam logic [2:0] ST_OFF     = S_OFF;
  localparam logic [2:0] ST_ON      = S_ON;
  localparam logic [2:0] ST_DIM     = S_DIM;
  localparam logic [2:0] ST_MAN_ON  = S_MAN_ON;
  localparam logic [2:0] ST_MAN_OFF = S_MAN_OFF;

  logic [3:0]    w_raw;
  logic [3:0]    w_in;
  logic          w_motion, w_dark, w_man_on, w_man_off, w_md;
  logic [2:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_hold, w_hold_nxt;
  logic [CW-1:0] r_dim, w_dim_nxt;
  logic          r_light, w_light_nxt;
  logic          w_pwm_clr, w_pwm_en, w_pwm_on;

  assign w_raw = {bus.motion, bus.light_level, bus.manual_on, bus.manual_off};

`ifdef SLS_INPUT_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic r_s1, r_s2;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
        end
      end
      assign w_in[gi] = r_s2;
    end
  endgenerate
`else
  assign w_in = w_raw;
`endif

  assign {w_motion, w_dark, w_man_on, w_man_off} = w_in;
  assign w_md = w_motion & w_dark;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_dim_nxt   = r_dim;
    w_pwm_clr   = 1'b0;
    w_pwm_en    = 1'b0;
    if (w_man_off)
      w_state_nxt = ST_MAN_OFF;
    else if (w_man_on)
      w_state_nxt = ST_MAN_ON;
    else begin
      case (r_state)
        ST_MAN_ON, ST_MAN_OFF: w_state_nxt = ST_OFF;
        ST_OFF: begin
          if (w_md) begin
            w_state_nxt = ST_ON;
            w_hold_nxt  = CW'(HOLD_CYCLES);
          end
        end
        ST_ON: begin
          if (!w_dark)
            w_state_nxt = ST_OFF;
          else if (w_md)
            w_hold_nxt = CW'(HOLD_CYCLES);
          else if (r_hold == CW'(1)) begin
            w_state_nxt = ST_DIM;
            w_dim_nxt   = CW'(DIM_CYCLES);
            w_pwm_clr   = 1'b1;
          end else
            w_hold_nxt = r_hold - CW'(1);
        end
        ST_DIM: begin
          // Daylight beats motion; motion beats dim expiry.
          if (!w_dark)
            w_state_nxt = ST_OFF;
          else if (w_md) begin
            w_state_nxt = ST_ON;
            w_hold_nxt  = CW'(HOLD_CYCLES);
          end else if (r_dim == CW'(1))
            w_state_nxt = ST_OFF;
          else begin
            w_dim_nxt = r_dim - CW'(1);
            w_pwm_en  = 1'b1;
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    w_light_nxt = 1'b0;
    case (w_state_nxt)
      ST_ON, ST_MAN_ON: w_light_nxt = 1'b1;
      ST_DIM:           w_light_nxt = w_pwm_on;
      default:          w_light_nxt = 1'b0;
    endcase
  end

  sls_pwm_dimmer #(
    .PWM_PERIOD (PWM_PERIOD),
    .DIM_DUTY   (DIM_DUTY)
  ) u_dimmer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_pwm_clr),
    .i_en     (w_pwm_en),
    .o_on_nxt (w_pwm_on)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_hold  <= '0;
      r_dim   <= '0;
      r_light <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_dim   <= w_dim_nxt;
      r_light <= w_light_nxt;
    end
  end

  assign bus.light = r_light;
endmodule

// File: tb/tb_smart_lighting_ctrl.sv
// Bench for smart_lighting_ctrl: directed scenarios plus random traffic against a timeline model.
// The model honours SLS_INPUT_SYNC_EN by delaying its view of the inputs by two edges.
module tb_smart_lighting_ctrl;
  localparam int H  = 4;
  localparam int D  = 8;
  localparam int P  = 4;
  localparam int DU = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  smart_lighting_ctrl_if bus();

  smart_lighting_ctrl #(
    .HOLD_CYCLES (H),
    .DIM_CYCLES  (D),
    .PWM_PERIOD  (P),
    .DIM_DUTY    (DU)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: automatic light is a timeline measured from the last motion-at-night edge.
  bit m_active;
  bit m_man;
  int m_since;
  bit m_light;
`ifdef SLS_INPUT_SYNC_EN
  bit [3:0] m_p1, m_p2;
`endif

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: light=%0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit [3:0] raw);
    bit [3:0] eff;
    bit mo, dk, on, of;
    if (rst) begin
      m_active = 0;
      m_man    = 0;
      m_since  = 0;
      m_light  = 0;
`ifdef SLS_INPUT_SYNC_EN
      m_p1 = '0;
      m_p2 = '0;
`endif
      return;
    end
`ifdef SLS_INPUT_SYNC_EN
    eff  = m_p2;
    m_p2 = m_p1;
    m_p1 = raw;
`else
    eff = raw;
`endif
    {mo, dk, on, of} = eff;
    if (of) begin
      m_man = 1; m_active = 0; m_light = 0;
    end else if (on) begin
      m_man = 1; m_active = 0; m_light = 1;
    end else begin
      if (m_man) begin
        m_man = 0; m_active = 0;
      end else if (mo && dk) begin
        m_active = 1; m_since = 0;
      end else if (m_active) begin
        if (!dk) m_active = 0;
        else begin
          m_since++;
          if (m_since >= H + D) m_active = 0;
        end
      end
      m_light = m_active && (m_since < H || ((m_since - H) % P) < DU);
    end
  endtask

  task automatic step(input bit rst, input bit mo, input bit dk, input bit on, input bit of,
                      input string tag);
    reset           = rst;
    bus.motion      = mo;
    bus.light_level = dk;
    bus.manual_on   = on;
    bus.manual_off  = of;
    @(posedge clk);
    model_edge(rst, {mo, dk, on, of});
    #1;
    chk(tag, bus.light, m_light);
  endtask

  bit exp_seq [16] = '{1,1,1,1, 0,0,0,1, 0,0,0,0, 0,0,0,0};

  initial begin
    reset = 1'b1;
    bus.motion = 0; bus.light_level = 0; bus.manual_on = 0; bus.manual_off = 0;
    #2;

    step(1, 0, 0, 0, 0, "reset");
    chk("reset_off", bus.light, 1'b0);

    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, "motion_dark");
`ifndef SLS_INPUT_SYNC_EN
    chk("on_after_motion", bus.light, 1'b1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 0, "hold_dim");
`ifndef SLS_INPUT_SYNC_EN
      chk("hold_dim_pattern", bus.light, exp_seq[i]);
`endif
    end

    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, "man_on");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "man_on_release");

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "day_motion");
    step(0, 0, 0, 0, 0, "day_idle");

    step(0, 1, 1, 0, 0, "enter_on");
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 1, "man_off");
`ifndef SLS_INPUT_SYNC_EN
    chk("man_off_dark", bus.light, 1'b0);
`endif
    step(0, 1, 1, 0, 0, "man_off_release");
`ifndef SLS_INPUT_SYNC_EN
    chk("release_to_off", bus.light, 1'b0);
`endif
    step(0, 1, 1, 0, 0, "auto_resume");
`ifndef SLS_INPUT_SYNC_EN
    chk("resume_on", bus.light, 1'b1);
`endif

    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, "to_dim");
    step(0, 1, 1, 0, 0, "dim_motion");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, "rehold");
    step(0, 1, 1, 0, 0, "on_again");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "day_kill");
    step(0, 0, 1, 1, 1, "both_manual");

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 3,
           "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
